// File: rtl/picorv32_mem_arbiter_if.sv
// Bus bundle for the two-master PicoRV32 memory arbiter: two native master
// ports plus the shared downstream port.
interface picorv32_mem_arbiter_if;
    logic        m0_valid;
    logic        m0_instr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_instr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic        s_instr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    // Arbiter side
    modport slave (
        input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    // Environment side: the two CPUs and the memory
    modport master (
        output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory interface: round-robin or
// fixed priority, one IDLE cycle between transactions, optional timeout abort.
module picorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    picorv32_mem_arbiter_if.slave        bus,
    output logic                         grant_id,
    output logic                         busy,
    output logic                         timeout_err
);
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic g_sel;
    logic g_valid;
    logic done;
    logic abort;
    logic pick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        g_sel        = (state_q == GRANT1);
        g_valid      = g_sel ? bus.m1_valid : bus.m0_valid;
        done         = 1'b0;
        abort        = 1'b0;
        pick         = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.m0_valid && bus.m1_valid) begin
                    pick = FIXED_PRIO ? 1'b0 : ~last_grant_q;
                end else begin
                    pick = bus.m1_valid;
                end
                if (bus.m0_valid || bus.m1_valid) begin
                    state_d      = pick ? GRANT1 : GRANT0;
                    last_grant_d = pick;
                end
            end
            GRANT0, GRANT1: begin
                // A master dropping valid is abandoned silently; s_ready beats timeout.
                if (!g_valid) begin
                    state_d = IDLE;
                end else if (bus.s_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_valid  = (state_q != IDLE) && g_valid && !abort;
    assign bus.s_instr  = g_sel ? bus.m1_instr : bus.m0_instr;
    assign bus.s_addr   = g_sel ? bus.m1_addr  : bus.m0_addr;
    assign bus.s_wdata  = g_sel ? bus.m1_wdata : bus.m0_wdata;
    assign bus.s_wstrb  = (state_q == IDLE) ? 4'b0000 : (g_sel ? bus.m1_wstrb : bus.m0_wstrb);

    assign bus.m0_ready = (state_q == GRANT0) && (done || abort);
    assign bus.m1_ready = (state_q == GRANT1) && (done || abort);
    assign bus.m0_rdata = ((state_q == GRANT0) && abort) ? ERR_RDATA : bus.s_rdata;
    assign bus.m1_rdata = ((state_q == GRANT1) && abort) ? ERR_RDATA : bus.s_rdata;

    assign timeout_err  = abort;
    assign busy         = (state_q != IDLE);
    assign grant_id     = last_grant_q;
endmodule
